// File: rtl/adc_sample_averager.sv
// adc_sample_averager: averages windows of 2^AVG_LOG2 ADC samples and
// offers each truncated mean on a valid/ready handshake.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   enable          - low holds the block cleared (IDLE)
//   data_ready      - one-cycle pulse qualifying adc_in
//   adc_in          - sample word
//   out_ready       - downstream accepts avg_out
//   out_valid       - avg_out holds an unconsumed result
//   avg_out         - window mean, truncated
//   overrun         - sticky: a completed window was discarded
//   stale           - no sample seen for TIMEOUT_CYCLES enabled cycles
module adc_sample_averager #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned AVG_LOG2       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] adc_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic                  overrun,
  output logic                  stale
);

  localparam int unsigned ACC_W = DATA_WIDTH + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned WIN   = 1 << AVG_LOG2;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   avg_q, avg_d;
  logic                    ovr_q, ovr_d;
  logic                    stale_q, stale_d;

  logic [ACC_W-1:0]        sum_c;
  logic                    last_c;

  // Running sum including the current sample; cannot overflow ACC_W bits.
  assign sum_c  = acc_q + ACC_W'(adc_in);
  assign last_c = (cnt_q == CNT_W'(WIN - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    valid_d = valid_q;
    avg_d   = avg_q;
    ovr_d   = ovr_q;
    stale_d = stale_q;

    if (!enable) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d = ACCUM;
    end

    if (!enable || state_q == IDLE) begin
      // Held cleared; entering ACCUM starts from a clean slate.
      acc_d   = '0;
      cnt_d   = '0;
      to_d    = '0;
      valid_d = 1'b0;
      avg_d   = '0;
      ovr_d   = 1'b0;
      stale_d = 1'b0;
    end else begin
      // A transfer this cycle frees the result register.
      if (valid_q && out_ready) valid_d = 1'b0;

      if (data_ready) begin
        to_d    = '0;
        stale_d = 1'b0;
        if (last_c) begin
          acc_d = '0;
          cnt_d = '0;
          if (!valid_q || out_ready) begin
            avg_d   = DATA_WIDTH'(sum_c >> AVG_LOG2);
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          acc_d = sum_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Saturating sample-free cycle counter.
        if (to_q != TO_W'(TIMEOUT_CYCLES)) to_d = to_q + TO_W'(1);
        stale_d = (to_d == TO_W'(TIMEOUT_CYCLES));
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      ovr_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      avg_q   <= avg_d;
      ovr_q   <= ovr_d;
      stale_q <= stale_d;
    end
  end

  assign out_valid = valid_q;
  assign avg_out   = avg_q;
  assign overrun   = ovr_q;
  assign stale     = stale_q;

endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Consumer for the ramp-ADC sample port: it captures each `adc_in` word qualified by a one-cycle `data_ready` pulse and accumulates windows of 2^AVG_LOG2 samples. Each completed window yields a truncated mean, offered downstream on a valid/ready handshake. The block sits between the ramp-ADC front end and display/logging logic. It flags lost results (overrun) and a stalled converter (stale).

## Interface
- DATA_WIDTH, 16, width of `adc_in` and `avg_out`
- AVG_LOG2, 4, log2 of samples per window (16 samples); legal range 0..8
- TIMEOUT_CYCLES, 1_000_000, enabled clock cycles without `data_ready` before `stale` asserts (10 ms at 100 MHz)

Ports:
- clk  in  1  system clock (100 MHz); single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  active-high; when low, the block is held cleared
- data_ready  in  1  one-cycle pulse qualifying `adc_in`
- adc_in  in  DATA_WIDTH  sample word
- out_ready  in  1  downstream accepts `avg_out`
- out_valid  out  1  `avg_out` holds an unconsumed result
- avg_out  out  DATA_WIDTH  window mean, truncated
- overrun  out  1  sticky; a completed window was discarded
- stale  out  1  no sample seen for TIMEOUT_CYCLES cycles

## Operation
- **States:** IDLE (enable low) and ACCUM.
  - IDLE→ACCUM when `enable`=1.
  - ACCUM→IDLE when `enable`=0.
  - `reset` forces IDLE from any state.
- **IDLE:** the following are all held at 0: accumulator, sample counter, timeout counter, `out_valid`, `avg_out`, `overrun`, `stale`.
- **Accumulator width:** DATA_WIDTH+AVG_LOG2 bits; it cannot overflow. The sample counter is AVG_LOG2+1 bits.
- **Sample intake in ACCUM:** each `data_ready` adds `adc_in`. `data_ready` in IDLE is ignored.
- **Window completion:** on the 2^AVG_LOG2-th sample, the result is (acc + adc_in) >> AVG_LOG2, truncated with no rounding. On that same edge the accumulator and counter restart at 0, so the next sample begins a new window with no gap.
- **Result register:** separate from the accumulator. Accumulation continues while a result is pending.
  - If `out_valid`=0, or `out_valid`&`out_ready` in the completion cycle: load the result and set `out_valid`=1.
  - If `out_valid`=1 and `out_ready`=0 in the completion cycle: discard the new result, keep `avg_out` unchanged, set `overrun`=1.
- **Handshake:**
  - A transfer occurs on a cycle with `out_valid`&`out_ready`; `out_valid` clears next edge unless a window completes that same cycle.
  - `avg_out` is stable while `out_valid`=1 and not transferred.
  - `out_ready` may be held high permanently.
- **overrun:** sticky; cleared only by `reset` or `enable`=0.
- **stale:**
  - The timeout counter increments each ACCUM cycle without `data_ready` and saturates at TIMEOUT_CYCLES.
  - `stale`=1 once the counter reaches TIMEOUT_CYCLES.
  - `data_ready` zeroes the counter and clears `stale` on the same edge.
  - `stale` does not affect accumulation.
- **Reset or disable mid-window:** the partial sum is discarded and no partial result is emitted.

## Timing
- **Reset values:** `out_valid`=0, `avg_out`=0, `overrun`=0, `stale`=0; state IDLE.
- **Latency:** final sample's `data_ready` at edge N → `out_valid`=1 and `avg_out` valid after edge N (visible in cycle N+1).
- **Back-to-back pulses:** `data_ready` on consecutive cycles must be accepted; every pulse is counted.
- **Stale assertion:** `stale` rises at the edge ending the TIMEOUT_CYCLES-th consecutive sample-free enabled cycle.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use AVG_LOG2=2 and TIMEOUT_CYCLES=50.
- **Basic average:** enable=1, out_ready=1; samples 0x0100, 0x0200, 0x0300, 0x0400 → `out_valid` pulses for 1 cycle, one cycle after the 4th sample, with `avg_out`=0x0280; `overrun`=0.
- **Truncation and back-to-back intake:** samples 1, 1, 1, 2 on consecutive cycles → `avg_out`=0x0001; the next 4 samples of 0xFFFF → `avg_out`=0xFFFF (no overflow).
- **Backpressure/overrun:** out_ready=0; 4×0x0FF0 then 4×0x0010 → first result 0x0FF0 is held, `overrun`=1 after the 8th sample, `avg_out` stays 0x0FF0. Raising out_ready transfers 0x0FF0, then `out_valid`=0 while `overrun` stays 1 until enable drops.
- **Simultaneous completion and transfer:** `out_valid`=1 holding 0x0280; `out_ready` raised in the same cycle as the 4th sample (4×0x0040) → `avg_out`=0x0040, `out_valid` stays 1, `overrun`=0.
- **Stale:** 50 enabled cycles with no `data_ready` → `stale`=1 at the edge ending cycle 50, not before. Next `data_ready` → `stale`=0 after that edge, and the sample is counted.
- **Reset mid-window:** 2 samples of 0x0800, then reset for 1 cycle → all outputs 0. Then 4×0x0100 → `avg_out`=0x0100, with no leftover partial sum. Repeat using enable=0 instead of reset → same result.
